reg_op_sequencer: RTL and testbench

//  Multi-cycle controller for the register-arithmetic unit (AU): accepts one incr/decr/jizr/jnzr op,

---
 rtl/reg_seq_pkg.sv | 26 ++
 rtl/reg_op_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_reg_op_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_seq_pkg.sv
// Shared types and defaults for the register-op sequencer.
package reg_seq_pkg;

  localparam int unsigned REG_AW_DEF = 3;
  localparam int unsigned DW_DEF     = 8;

  typedef enum logic [1:0] {
    OP_INCR = 2'b00,
    OP_DECR = 2'b01,
    OP_JIZR = 2'b10,
    OP_JNZR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_READ   = 2'b01,
    S_EXEC   = 2'b10,
    S_RETIRE = 2'b11
  } state_e;

  // Branch ops share the upper opcode bit.
  function automatic logic is_branch(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/reg_op_sequencer.sv
// Multi-cycle controller for the register-arithmetic unit.
// Sequence per op: IDLE (accept) -> READ -> EXEC -> RETIRE.
// Optional build macro: REG_SEQ_SATURATE_EN makes incr/decr saturate and drive sat.
module reg_op_sequencer
  import reg_seq_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned DW     = DW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [REG_AW-1:0] op_reg,
  input  logic [2:0]        op_v,
  input  logic [DW-1:0]     pc_in,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DW-1:0]     rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic [DW-1:0]     au_x,
  output logic [2:0]        au_v,
  output logic              au_incr,
  output logic              au_decr,
  output logic              au_jizr,
  output logic              au_jnzr,
  input  logic [DW-1:0]     au_res,
  output logic              br_valid,
  output logic              br_taken,
  output logic [DW-1:0]     br_target,
  output logic              done,
  output logic              sat
);

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_next_state;
  logic              w_accept;
  op_e               r_op;
  logic [REG_AW-1:0] r_reg;
  logic [2:0]        r_v;
  logic [DW-1:0]     r_pc;
  logic [DW-1:0]     r_result;
  logic [DW-1:0]     r_target;
  logic              r_taken;
  logic              w_taken;
  logic              w_is_br;
  logic [DW-1:0]     w_result;
  logic              w_retire;
`ifdef REG_SEQ_SATURATE_EN
  logic              w_sat;
  logic              r_sat;
`endif

  // State register; reset discards any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; an op is accepted only from IDLE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          w_next_state = S_READ;
          w_accept     = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_READ:   w_next_state = S_EXEC;
      S_EXEC:   w_next_state = S_RETIRE;
      S_RETIRE: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // AU drive during EXEC: register value for incr/decr, latched PC and offset for branches.
  always_comb begin
    au_x    = {DW{1'b0}};
    au_v    = 3'b000;
    au_incr = 1'b0;
    au_decr = 1'b0;
    au_jizr = 1'b0;
    au_jnzr = 1'b0;
    if (r_state == S_EXEC) begin
      case (r_op)
        OP_INCR: begin au_incr = 1'b1; au_x = rf_rdata; end
        OP_DECR: begin au_decr = 1'b1; au_x = rf_rdata; end
        OP_JIZR: begin au_jizr = 1'b1; au_x = r_pc; au_v = r_v; end
        OP_JNZR: begin au_jnzr = 1'b1; au_x = r_pc; au_v = r_v; end
        default: begin au_x = {DW{1'b0}}; end
      endcase
    end else begin
      au_x = {DW{1'b0}};
    end
  end

  // Branch condition and write-back value, evaluated from the read data in EXEC.
  always_comb begin
    w_is_br = is_branch(r_op);
    if (r_op == OP_JIZR) begin
      w_taken = (rf_rdata == {DW{1'b0}});
    end else begin
      w_taken = (rf_rdata != {DW{1'b0}});
    end
`ifdef REG_SEQ_SATURATE_EN
    w_sat = ((r_op == OP_INCR) && (rf_rdata == {DW{1'b1}})) ||
            ((r_op == OP_DECR) && (rf_rdata == {DW{1'b0}}));
    if (w_sat) begin
      w_result = rf_rdata;
    end else begin
      w_result = au_res;
    end
`else
    w_result = au_res;
`endif
  end

  // Op latch at accept and result/target capture at the end of EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_INCR;
      r_reg    <= {REG_AW{1'b0}};
      r_v      <= 3'b000;
      r_pc     <= {DW{1'b0}};
      r_result <= {DW{1'b0}};
      r_target <= {DW{1'b0}};
      r_taken  <= 1'b0;
`ifdef REG_SEQ_SATURATE_EN
      r_sat    <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_op  <= op_e'(op_code);
        r_reg <= op_reg;
        r_v   <= op_v;
        r_pc  <= pc_in;
      end
      if (r_state == S_EXEC) begin
        r_taken <= w_taken;
        if (w_is_br) begin
          // Not-taken target is computed here rather than by the AU.
          r_target <= w_taken ? au_res : (r_pc + ONE);
        end else begin
          r_result <= w_result;
        end
`ifdef REG_SEQ_SATURATE_EN
        r_sat <= w_sat;
`endif
      end
    end
  end

  assign w_retire  = (r_state == S_RETIRE);
  assign op_ready  = (r_state == S_IDLE);
  assign rf_raddr  = r_reg;
  assign rf_waddr  = r_reg;
  assign rf_wdata  = r_result;
  assign rf_we     = w_retire && !is_branch(r_op);
  assign br_valid  = w_retire && is_branch(r_op);
  assign br_taken  = w_retire && is_branch(r_op) && r_taken;
  assign br_target = r_target;
  assign done      = w_retire;
`ifdef REG_SEQ_SATURATE_EN
  assign sat       = w_retire && r_sat;
`else
  assign sat       = 1'b0;
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed scoreboard bench for reg_op_sequencer with a register-file and AU model.
// Honours REG_SEQ_SATURATE_EN for the expected incr/decr edge results.
module tb_reg_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op_code;
  logic [2:0] op_reg;
  logic [2:0] op_v;
  logic [7:0] pc_in;
  logic [2:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] au_x;
  logic [2:0] au_v;
  logic       au_incr, au_decr, au_jizr, au_jnzr;
  logic [7:0] au_res;
  logic       br_valid, br_taken;
  logic [7:0] br_target;
  logic       done, sat;

  int total = 0;
  int bad   = 0;
  int cnt_we = 0;
  int cnt_done = 0;

  logic       pl_en = 1'b0;
  logic [2:0] pl_addr = 3'd0;
  logic [7:0] pl_data = 8'd0;
  logic [7:0] mem [8];
  logic [7:0] mdl [8];

  typedef struct packed {
    logic       is_br;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       taken;
    logic [7:0] target;
    logic       sat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  reg_op_sequencer dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_reg(op_reg), .op_v(op_v), .pc_in(pc_in),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .au_x(au_x), .au_v(au_v),
    .au_incr(au_incr), .au_decr(au_decr), .au_jizr(au_jizr), .au_jnzr(au_jnzr),
    .au_res(au_res), .br_valid(br_valid), .br_taken(br_taken),
    .br_target(br_target), .done(done), .sat(sat)
  );

  // Register file model: synchronous read, write port plus preload port.
  always @(posedge clk) begin
    rf_rdata <= mem[rf_raddr];
    if (rf_we) mem[rf_waddr] <= rf_wdata;
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  // AU model: increment, decrement, or pc + 2*v.
  always_comb begin
    au_res = 8'h00;
    if (au_incr) au_res = au_x + 8'd1;
    else if (au_decr) au_res = au_x - 8'd1;
    else if (au_jizr || au_jnzr) au_res = au_x + {4'b0000, au_v, 1'b0};
  end

  // Pulse counters.
  always @(posedge clk) begin
    if (rf_we) cnt_we <= cnt_we + 1;
    if (done) cnt_done <= cnt_done + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [1:0] code, input logic [2:0] r,
                                 input logic [7:0] rv, input logic [2:0] v,
                                 input logic [7:0] pc);
    exp_t e;
    e = '0;
    e.waddr = r;
    case (code)
      2'b00: begin
        e.wdata = rv + 8'd1;
`ifdef REG_SEQ_SATURATE_EN
        if (rv == 8'hFF) begin e.wdata = 8'hFF; e.sat = 1'b1; end
`endif
      end
      2'b01: begin
        e.wdata = rv - 8'd1;
`ifdef REG_SEQ_SATURATE_EN
        if (rv == 8'h00) begin e.wdata = 8'h00; e.sat = 1'b1; end
`endif
      end
      2'b10: begin e.is_br = 1'b1; e.taken = (rv == 8'h00); end
      default: begin e.is_br = 1'b1; e.taken = (rv != 8'h00); end
    endcase
    if (e.is_br) e.target = e.taken ? (pc + {4'b0000, v, 1'b0}) : (pc + 8'd1);
    return e;
  endfunction

  task automatic handle_done();
    exp_t e;
    if (done === 1'b1) begin
      check("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("br_valid", br_valid, e.is_br);
        check("rf_we", rf_we, !e.is_br);
        check("sat", sat, e.sat);
        if (e.is_br) begin
          check("br_taken", br_taken, e.taken);
          check("br_target", br_target, e.target);
        end else begin
          check("rf_waddr", rf_waddr, e.waddr);
          check("rf_wdata", rf_wdata, e.wdata);
        end
      end
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    mdl[a] = d;
  endtask

  function automatic void push_op(input logic [1:0] code, input logic [2:0] r,
                                  input logic [2:0] v, input logic [7:0] pc);
    exp_t e;
    e = model(code, r, mdl[r], v, pc);
    if (!e.is_br) mdl[r] = e.wdata;
    sb.push_back(e);
  endfunction

  // One op from IDLE; inputs are scrambled and op_valid kept high mid-op.
  task automatic do_op(input logic [1:0] code, input logic [2:0] r,
                       input logic [2:0] v, input logic [7:0] pc);
    bit got;
    got = 1'b0;
    check("ready_idle", op_ready, 1);
    push_op(code, r, v, pc);
    op_valid = 1'b1; op_code = code; op_reg = r; op_v = v; pc_in = pc;
    for (int n = 1; n <= 8; n++) begin
      if (!got) begin
        @(negedge clk);
        op_code = ~code; op_reg = ~r; op_v = ~v; pc_in = ~pc;
        if (done === 1'b1) begin
          got = 1'b1;
          check("latency", n, 3);
          handle_done();
          op_valid = 1'b0;
        end else begin
          check("ready_busy", op_ready, 0);
        end
      end
    end
    if (!got) begin
      check("done_seen", 0, 1);
      op_valid = 1'b0;
      void'(sb.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    int we0;
    int done0;
    reset = 1'b1; op_valid = 1'b0; op_code = 2'b00; op_reg = 3'd0;
    op_v = 3'd0; pc_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_op_ready", op_ready, 1);
    check("rst_strobes", {rf_we, br_valid, br_taken, done, sat}, 5'b0);
    check("rst_au_sel", {au_incr, au_decr, au_jizr, au_jnzr}, 4'b0);
    check("rst_addr_data", {rf_raddr, rf_waddr, rf_wdata, au_x, au_v, br_target}, 0);
    reset = 1'b0;
    @(negedge clk);

    preload(3'd3, 8'h41);
    preload(3'd0, 8'h00);
    preload(3'd5, 8'h00);
    preload(3'd7, 8'hFF);
    preload(3'd2, 8'h10);
    preload(3'd1, 8'h05);

    do_op(2'b00, 3'd3, 3'd0, 8'h10);   // incr r3 0x41
    do_op(2'b01, 3'd0, 3'd0, 8'h11);   // decr r0 0x00
    do_op(2'b00, 3'd7, 3'd0, 8'h12);   // incr r7 0xFF
    we0 = cnt_we;
    do_op(2'b10, 3'd5, 3'd3, 8'h20);   // jizr taken -> 0x26
    do_op(2'b11, 3'd5, 3'd3, 8'hFF);   // jnzr not taken -> 0x00
    do_op(2'b10, 3'd5, 3'd0, 8'h80);   // jizr v=0 taken -> pc
    check("branch_no_we", cnt_we - we0, 0);
    preload(3'd5, 8'h01);
    do_op(2'b11, 3'd5, 3'd2, 8'hFC);   // jnzr taken -> 0x00

    // Back-to-back ops with op_valid held high.
    op_valid = 1'b1; op_code = 2'b00; op_reg = 3'd2; op_v = 3'd0; pc_in = 8'h40;
    for (int k = 0; k < 12; k++) begin
      check("b2b_ready", op_ready, (k % 4 == 0));
      if (op_ready === 1'b1) push_op(2'b00, 3'd2, 3'd0, 8'h40);
      handle_done();
      @(negedge clk);
      if (k == 11) op_valid = 1'b0;
    end
    @(negedge clk);

    // Reset during EXEC of incr r1 discards the op.
    we0 = cnt_we; done0 = cnt_done;
    op_valid = 1'b1; op_code = 2'b00; op_reg = 3'd1; op_v = 3'd0; pc_in = 8'h50;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    check("exec_au_incr", au_incr, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", op_ready, 1);
    check("mid_rst_strobes", {rf_we, br_valid, br_taken, done, sat}, 5'b0);
    check("mid_rst_au_sel", {au_incr, au_decr, au_jizr, au_jnzr}, 4'b0);
    check("mid_rst_addr_data", {rf_raddr, rf_waddr, rf_wdata, au_x, au_v, br_target}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_no_we", cnt_we - we0, 0);
    check("mid_rst_no_done", cnt_done - done0, 0);
    do_op(2'b00, 3'd1, 3'd0, 8'h60);   // r1 still 0x05 -> 0x06

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
